// File: rtl/song_menu_fsm.sv
// Song-select menu with per-song high-score table for the game front end.
// Walks a cursor over the song list, launches a game and keeps each song's best score.
module song_menu_fsm #(
   parameter int NUM_SONGS  = 4,
   parameter int SEL_W      = 2,
   parameter int SCORE_W    = 18,
   parameter int ASCII_W    = 48,
   parameter int WRAP       = 0,
   parameter int RESULT_CYC = 65000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               up,
   input  logic               down,
   input  logic               enter,
   input  logic               done,
   input  logic [SCORE_W-1:0] binaryIn,
   input  logic [ASCII_W-1:0] asciiIn,
   output logic [1:0]         menuState,
   output logic [SEL_W-1:0]   cursor,
   output logic [SEL_W-1:0]   song,
   output logic               resetComp,
   output logic [ASCII_W-1:0] highScore,
   output logic               newRecord
);

   typedef enum logic [1:0] {
      ST_MENU   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   localparam int               TIMER_W    = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESULT_CYC - 1);
   localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_SONGS - 1);
   localparam logic [ASCII_W-1:0] ASCII_ZERO = {(ASCII_W/8){8'h30}};

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     cursor_q, cursor_d;
   logic [SEL_W-1:0]     song_q, song_d;
   logic                 reset_comp_q, reset_comp_d;
   logic                 new_record_q, new_record_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 up_q, down_q, enter_q;
   logic                 wr_en;
   logic [SEL_W-1:0]     disp_idx;
   logic [ASCII_W-1:0]   high_score_q;

   logic [SCORE_W-1:0]   score_bin_q [NUM_SONGS];
   logic [ASCII_W-1:0]   score_asc_q [NUM_SONGS];

   logic up_rise, down_rise, enter_rise;

   assign up_rise    = up    & ~up_q;
   assign down_rise  = down  & ~down_q;
   assign enter_rise = enter & ~enter_q;

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      cursor_d     = cursor_q;
      song_d       = song_q;
      reset_comp_d = 1'b0;
      new_record_d = new_record_q;
      timer_d      = timer_q;
      wr_en        = 1'b0;

      case (state_q)
         ST_MENU: begin
            if (enter_rise) begin
               song_d       = cursor_q;
               reset_comp_d = 1'b1;
               new_record_d = 1'b0;
               state_d      = ST_PLAY;
            end else if (down_rise && !up_rise) begin
               if (cursor_q == LAST_IDX) cursor_d = (WRAP != 0) ? '0 : cursor_q;
               else                      cursor_d = cursor_q + SEL_W'(1);
            end else if (up_rise && !down_rise) begin
               if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST_IDX : cursor_q;
               else                cursor_d = cursor_q - SEL_W'(1);
            end
         end

         ST_PLAY: begin
            if (done) begin
               state_d = ST_RESULT;
               timer_d = TIMER_LOAD;
               // Strictly greater: ties keep the earlier entry, and 0 can never beat the reset value.
               if (binaryIn > score_bin_q[song_q]) begin
                  wr_en        = 1'b1;
                  new_record_d = 1'b1;
               end
            end
         end

         ST_RESULT: begin
            if (timer_q == '0 || enter_rise) begin
               state_d      = ST_MENU;
               new_record_d = 1'b0;
               cursor_d     = song_q;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         default: state_d = ST_MENU;
      endcase
   end

   assign disp_idx = (state_q == ST_MENU) ? cursor_q : song_q;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_MENU;
         cursor_q     <= '0;
         song_q       <= '0;
         reset_comp_q <= 1'b0;
         new_record_q <= 1'b0;
         timer_q      <= '0;
         up_q         <= 1'b0;
         down_q       <= 1'b0;
         enter_q      <= 1'b0;
         high_score_q <= ASCII_ZERO;
         // NOTE: the score table is deliberately reset; it is small and reset must clear every record.
         for (int i = 0; i < NUM_SONGS; i++) begin
            score_bin_q[i] <= '0;
            score_asc_q[i] <= ASCII_ZERO;
         end
      end else begin
         state_q      <= state_d;
         cursor_q     <= cursor_d;
         song_q       <= song_d;
         reset_comp_q <= reset_comp_d;
         new_record_q <= new_record_d;
         timer_q      <= timer_d;
         up_q         <= up;
         down_q       <= down;
         enter_q      <= enter;
         high_score_q <= score_asc_q[disp_idx];
         if (wr_en) begin
            score_bin_q[song_q] <= binaryIn;
            score_asc_q[song_q] <= asciiIn;
         end
      end
   end

   assign menuState = state_q;
   assign cursor    = cursor_q;
   assign song      = song_q;
   assign resetComp = reset_comp_q;
   assign highScore = high_score_q;
   assign newRecord = new_record_q;

endmodule

// File: tb/tb_song_menu_fsm.sv
// Directed bench for song_menu_fsm: a saturating instance and a wrapping instance share stimulus.
module tb_song_menu_fsm;

   localparam int NS = 4;
   localparam int SW = 2;
   localparam int BW = 18;
   localparam int AW = 48;
   localparam logic [AW-1:0] ZERO_A = {6{8'h30}};

   logic          clk = 1'b0;
   logic          reset, up, down, enter, done;
   logic [BW-1:0] binaryIn;
   logic [AW-1:0] asciiIn;

   logic [1:0]    menuState, menuState_w;
   logic [SW-1:0] cursor, cursor_w, song, song_w;
   logic          resetComp, resetComp_w, newRecord, newRecord_w;
   logic [AW-1:0] highScore, highScore_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   song_menu_fsm #(.NUM_SONGS(NS), .SEL_W(SW), .SCORE_W(BW), .ASCII_W(AW),
                   .WRAP(0), .RESULT_CYC(10)) dut (
      .clk(clk), .reset(reset), .up(up), .down(down), .enter(enter), .done(done),
      .binaryIn(binaryIn), .asciiIn(asciiIn), .menuState(menuState), .cursor(cursor),
      .song(song), .resetComp(resetComp), .highScore(highScore), .newRecord(newRecord));

   song_menu_fsm #(.NUM_SONGS(NS), .SEL_W(SW), .SCORE_W(BW), .ASCII_W(AW),
                   .WRAP(1), .RESULT_CYC(10)) dut_w (
      .clk(clk), .reset(reset), .up(up), .down(down), .enter(enter), .done(done),
      .binaryIn(binaryIn), .asciiIn(asciiIn), .menuState(menuState_w), .cursor(cursor_w),
      .song(song_w), .resetComp(resetComp_w), .highScore(highScore_w), .newRecord(newRecord_w));

   // Inputs change and outputs are sampled on the falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; up = 1'b0; down = 1'b0; enter = 1'b0; done = 1'b0;
      binaryIn = '0; asciiIn = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // m = {enter, up, down}; one-cycle pulse, then one idle cycle so highScore has caught up.
   task automatic press(input logic [2:0] m);
      @(negedge clk);
      enter = m[2]; up = m[1]; down = m[0];
      @(negedge clk);
      enter = 1'b0; up = 1'b0; down = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (menuState !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", menuState); end
      total++; if (cursor !== 2'd0) begin bad++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
      total++; if (song !== 2'd0) begin bad++; $display("FAIL reset_song got=%0d exp=0", song); end
      total++; if (resetComp !== 1'b0 || newRecord !== 1'b0) begin
         bad++; $display("FAIL reset_flags got rc=%b nr=%b exp 0 0", resetComp, newRecord);
      end
      total++; if (highScore !== ZERO_A) begin bad++; $display("FAIL reset_high got=%s exp=%s", highScore, ZERO_A); end
   endtask

   task automatic test_down_sweep();
      logic [SW-1:0] exp_sat [5];
      logic [SW-1:0] exp_wrp [5];
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_wrp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         press(3'b001);
         total++; if (cursor !== exp_sat[i]) begin
            bad++; $display("FAIL down_sat[%0d] got=%0d exp=%0d", i, cursor, exp_sat[i]);
         end
         total++; if (cursor_w !== exp_wrp[i]) begin
            bad++; $display("FAIL down_wrap[%0d] got=%0d exp=%0d", i, cursor_w, exp_wrp[i]);
         end
      end
      do_reset();
      press(3'b010);
      total++; if (cursor !== 2'd0) begin bad++; $display("FAIL up_sat_at0 got=%0d exp=0", cursor); end
      total++; if (cursor_w !== 2'd3) begin bad++; $display("FAIL up_wrap_at0 got=%0d exp=3", cursor_w); end
   endtask

   task automatic test_hold_and_conflict();
      do_reset();
      @(negedge clk);
      down = 1'b1;
      repeat (100) @(negedge clk);
      total++; if (cursor !== 2'd1) begin bad++; $display("FAIL hold_down got=%0d exp=1", cursor); end
      down = 1'b0;
      press(3'b011);
      total++; if (cursor !== 2'd1) begin bad++; $display("FAIL up_down_same got=%0d exp=1", cursor); end
      press(3'b101);
      total++; if (menuState !== 2'd1 || song !== 2'd1 || cursor !== 2'd1) begin
         bad++; $display("FAIL enter_prio got st=%0d song=%0d cur=%0d exp 1 1 1", menuState, song, cursor);
      end
   endtask

   task automatic test_play_record();
      int cnt;
      do_reset();
      press(3'b001);
      press(3'b001);
      @(negedge clk);
      enter = 1'b1;
      @(negedge clk);
      total++; if (resetComp !== 1'b1 || menuState !== 2'd1 || song !== 2'd2) begin
         bad++; $display("FAIL start got rc=%b st=%0d song=%0d exp 1 1 2", resetComp, menuState, song);
      end
      enter = 1'b0;
      @(negedge clk);
      total++; if (resetComp !== 1'b0) begin bad++; $display("FAIL rc_pulse got=%b exp=0", resetComp); end
      press(3'b010);
      total++; if (cursor !== 2'd2 || menuState !== 2'd1) begin
         bad++; $display("FAIL play_ignore got cur=%0d st=%0d exp 2 1", cursor, menuState);
      end
      done = 1'b1; binaryIn = 18'd1234; asciiIn = "001234";
      @(negedge clk);
      done = 1'b0;
      total++; if (menuState !== 2'd2 || newRecord !== 1'b1) begin
         bad++; $display("FAIL record got st=%0d nr=%b exp 2 1", menuState, newRecord);
      end
      cnt = 1;
      @(negedge clk);
      total++; if (highScore !== "001234") begin bad++; $display("FAIL high_after_done got=%s exp=001234", highScore); end
      if (menuState == 2'd2) cnt++;
      for (int i = 0; i < 40 && menuState == 2'd2; i++) begin
         @(negedge clk);
         if (menuState == 2'd2) cnt++;
      end
      total++; if (cnt !== 10) begin bad++; $display("FAIL result_len got=%0d exp=10", cnt); end
      total++; if (menuState !== 2'd0 || cursor !== 2'd2 || newRecord !== 1'b0) begin
         bad++; $display("FAIL back_menu got st=%0d cur=%0d nr=%b exp 0 2 0", menuState, cursor, newRecord);
      end
      @(negedge clk);
      total++; if (highScore !== "001234") begin bad++; $display("FAIL high_menu got=%s exp=001234", highScore); end
      press(3'b010);
      total++; if (highScore !== ZERO_A) begin bad++; $display("FAIL entry1_untouched got=%s exp=%s", highScore, ZERO_A); end
      press(3'b001);
      press(3'b001);
      total++; if (highScore !== ZERO_A) begin bad++; $display("FAIL entry3_untouched got=%s exp=%s", highScore, ZERO_A); end
      press(3'b010);
   endtask

   // Entry 2 already holds 1234; replay with a tie and then a lower score, skipping RESULT with enter.
   task automatic test_no_overwrite();
      logic [BW-1:0] sc [2];
      logic [AW-1:0] as [2];
      sc = '{18'd1234, 18'd1000};
      as = '{"009999", "001000"};
      for (int g = 0; g < 2; g++) begin
         press(3'b100);
         @(negedge clk);
         done = 1'b1; binaryIn = sc[g]; asciiIn = as[g];
         @(negedge clk);
         done = 1'b0;
         total++; if (menuState !== 2'd2 || newRecord !== 1'b0) begin
            bad++; $display("FAIL no_record[%0d] got st=%0d nr=%b exp 2 0", g, menuState, newRecord);
         end
         @(negedge clk);
         @(negedge clk);
         total++; if (menuState !== 2'd2) begin bad++; $display("FAIL result_hold[%0d] got=%0d exp=2", g, menuState); end
         enter = 1'b1;
         @(negedge clk);
         enter = 1'b0;
         total++; if (menuState !== 2'd0) begin bad++; $display("FAIL enter_skip[%0d] got=%0d exp=0", g, menuState); end
         @(negedge clk);
         total++; if (highScore !== "001234") begin
            bad++; $display("FAIL kept_entry[%0d] got=%s exp=001234", g, highScore);
         end
      end
   endtask

   task automatic test_reset_mid_play();
      press(3'b001);
      press(3'b100);
      total++; if (menuState !== 2'd1 || song !== 2'd3) begin
         bad++; $display("FAIL pre_reset_play got st=%0d song=%0d exp 1 3", menuState, song);
      end
      @(negedge clk);
      reset = 1'b1; done = 1'b1; binaryIn = 18'd5000; asciiIn = "005000";
      @(negedge clk);
      reset = 1'b0; done = 1'b0;
      total++; if (menuState !== 2'd0 || newRecord !== 1'b0 || cursor !== 2'd0) begin
         bad++; $display("FAIL reset_mid_play got st=%0d nr=%b cur=%0d exp 0 0 0", menuState, newRecord, cursor);
      end
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         total++; if (highScore !== ZERO_A) begin
            bad++; $display("FAIL cleared_entry[%0d] got=%s exp=%s", i, highScore, ZERO_A);
         end
         if (i < NS - 1) press(3'b001);
      end
   endtask

   initial begin
      reset = 1'b1; up = 1'b0; down = 1'b0; enter = 1'b0; done = 1'b0;
      binaryIn = '0; asciiIn = '0;
      test_reset();
      test_down_sweep();
      test_hold_and_conflict();
      test_play_record();
      test_no_overwrite();
      test_reset_mid_play();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
